cga_scandoubler: RTL and testbench
==================================

# cga_scandoubler

Line doubler that takes the 18-bit RGB pixel stream produced by the CGA video output stage (15.7 kHz line rate) and re-emits every line twice at double pixel and line rate, so that a standard 31 kHz VGA monitor can display it. The block sits directly downstream of the RGB/composite colour stage. It captures one line into a ping-pong line buffer while replaying the previously captured line twice. Output hsync is regenerated from the measured input line period.

## Interface
Parameters:
- LINE_MAX, 1024: line buffer depth in pixels; address width is clog2(LINE_MAX).
- OUT_DIV, 1: clk cycles per output pixel strobe. The input pixel strobe period must be 2*OUT_DIV.
- HS_OUT_W, 54: output hsync width, in output strobes.
- BP_OUT, 60: output back porch, in output strobes, from hsync deassert to first pixel.

Ports:
- clk, in, 1: single system clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high.
- pix_ce_in, in, 1: one-cycle strobe marking a valid input pixel.
- red_in / green_in / blue_in, in, 6 each: input pixel colour.
- hsync_in, in, 1: input horizontal sync, active high.
- vsync_in, in, 1: input vertical sync, active high.
- ce_out, out, 1: output pixel strobe.
- red_out / green_out / blue_out, out, 6 each: doubled pixel colour.
- hsync_out, out, 1: regenerated horizontal sync, active high.
- vsync_out, out, 1: vsync resampled at output half-line starts.
- de_out, out, 1: high while red/green/blue_out carry buffered pixels.
- overflow, out, 1: sticky; set when an input line exceeds LINE_MAX.

## Operation
- **Edge detect:** hsync_in is registered once. A rising edge (hs_edge) is detected on the registered value.
- **Write side:** on pix_ce_in with wr_addr < LINE_MAX:
  - write {blue,green,red} to buffer[wr_sel][wr_addr];
  - increment wr_addr.
- **Write overflow:** on pix_ce_in with wr_addr == LINE_MAX, drop the pixel and set overflow. Only reset clears overflow.
- **On hs_edge:**
  - line_len <= wr_addr; wr_addr <= 0; wr_sel toggles;
  - period <= per_cnt; half <= per_cnt>>1; per_cnt <= 1.
  - Otherwise per_cnt increments, saturating at 16'hFFFF.
- **Read side:** always reads buffer[~wr_sel], the last complete line.
- **Half-line start (HLS):** fires on hs_edge, and also when per_cnt == half with half != 0. The per_cnt == half HLS fires only once per input line.
- **At every HLS:**
  - out_div counter resets to 0, so ce_out is asserted that cycle;
  - vsync_out <= registered vsync_in;
  - the output FSM enters SYNC with step <= 0, rd_addr <= 0.
- **ce_out:** asserted when out_div == 0; out_div counts 0..OUT_DIV-1 and wraps.
- **Output FSM** (advances only on ce_out):
  - SYNC: hsync_out=1; after HS_OUT_W strobes go to BACK.
  - BACK: after BP_OUT strobes go to ACTIVE; if line_len == 0 go to IDLE.
  - ACTIVE: issue a read at rd_addr and increment it; after line_len strobes go to IDLE.
  - IDLE: output black, de_out=0; wait for HLS.
- **HLS during any state** aborts the current pass and restarts at SYNC, truncating the line. This is not an error.
- **Before valid data:** until two hs_edges have occurred since reset, line_valid=0. In that case the HLS at per_cnt == half is suppressed and ACTIVE outputs black with de_out=0.
- **Widths:** per_cnt, period and half are 16 bits. line_len and rd_addr are clog2(LINE_MAX)+1 bits.

## Timing
- **Reset values:**
  - ce_out=0, red/green/blue_out=0, hsync_out=0, vsync_out=0, de_out=0, overflow=0;
  - FSM=IDLE, wr_sel=0, wr_addr=0, per_cnt=0, line_valid=0.
- **Read latency:** buffer read is synchronous (1 clk), followed by an output register. The pixel read on the ACTIVE strobe at cycle N is visible on red/green/blue_out and de_out at cycle N+2, and holds until the next update.
- **hsync_out** rises 1 clk after the HLS cycle. It falls 1 clk after the HS_OUT_W-th strobe.
- **hs_edge** occurs 2 clk after hsync_in rises: one clk for the input register, one for edge detection.
- **Simultaneous write and read** of the same buffer is impossible by construction, since they always use opposite wr_sel.
- **Simultaneous pix_ce_in and hs_edge:** the pixel is written to the old buffer at the old wr_addr before the swap, and is counted in line_len.
- **Reset mid-line:** all state returns to reset values on the next clk. Buffer RAM contents are not cleared.

## Test plan
- **Reset:** hold reset 3 cycles -> all outputs 0 and FSM IDLE; the first HLS produces no de_out.
- **Doubling:**
  - Stimulus: OUT_DIV=1, HS_OUT_W=4, BP_OUT=2; pix_ce_in every 2 clk; 4 pixels 0x00001, 0x00FC0, 0x3F000, 0x3FFFF; input line period 40 clk; 3 lines.
  - Required response: during line 3, two output half-lines each show the 4 pixels in order, with de_out high for 4 strobes starting 6 strobes + 2 clk after HLS.
- **Overflow:** LINE_MAX=1024, 1030 pixels in one line -> overflow=1 and stays set; next-line replay shows 1024 pixels, de_out high 1024 strobes.
- **Period split:** input hsync period 1000 clk -> hsync_out rises at offsets 1 and 501 clk after each hs_edge (+2 from the hsync_in edge).
- **Truncation:** line_len=300 with half-line 200 strobes -> ACTIVE aborted, SYNC restarts, no stale pixel emitted after HLS+1.
- **vsync and mid-line reset:** vsync_in high for 2 input lines -> vsync_out high for 4 half-lines; reset asserted mid-ACTIVE -> outputs 0 next clk and line_valid=0.

Source files
------------

// File: rtl/cga_scandoubler.sv
// cga_scandoubler: re-emits each 15.7 kHz CGA RGB line twice at 31 kHz VGA rate through a ping-pong line buffer.
// Ports: clk, reset (sync, active high);
//        input stream: pix_ce_in, red_in/green_in/blue_in[5:0], hsync_in, vsync_in;
//        output stream: ce_out, red_out/green_out/blue_out[5:0], hsync_out, vsync_out, de_out;
//        overflow: sticky flag for an input line longer than LINE_MAX.
module cga_scandoubler #(
  parameter int LINE_MAX = 1024,
  parameter int OUT_DIV  = 1,
  parameter int HS_OUT_W = 54,
  parameter int BP_OUT   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce_in,
  input  logic [5:0] red_in,
  input  logic [5:0] green_in,
  input  logic [5:0] blue_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       ce_out,
  output logic [5:0] red_out,
  output logic [5:0] green_out,
  output logic [5:0] blue_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic       overflow
);
  localparam int AW = $clog2(LINE_MAX);
  localparam logic [AW:0] LMAX = (AW+1)'(LINE_MAX);
  typedef enum logic [1:0] {IDLE, SYNC, BACK, ACTIVE} state_t;
  state_t state_q, state_d;
  logic hs_q, hs_d, hs_prev_q, hs_prev_d, vs_q, vs_d;
  logic wr_sel_q, wr_sel_d;
  logic [AW:0] wr_addr_q, wr_addr_d, line_len_q, line_len_d, rd_addr_q, rd_addr_d;
  logic overflow_q, overflow_d;
  logic [15:0] per_cnt_q, per_cnt_d, half_q, half_d, div_q, div_d, step_q, step_d;
  logic half_done_q, half_done_d, started_q, started_d;
  logic [1:0] edges_q, edges_d;
  logic vsync_out_q, vsync_out_d;
  logic p1_upd_q, p1_upd_d, p1_vld_q, p1_vld_d, de_q, de_d;
  logic [17:0] rd_data_q, pix_q, pix_d;
  logic [17:0] mem [2**(AW+1)];
  logic hs_edge, line_valid, hls, ce, wr_en;
  assign hs_edge = hs_q & ~hs_prev_q;
  assign line_valid = edges_q[1];
  // second half-line start: once per input line, only once real line data exists
  assign hls = hs_edge | (line_valid & (half_q != '0) & (per_cnt_q == half_q) & ~half_done_q);
  // no strobes until the first half-line start so ce_out stays low out of reset
  assign ce = started_q & (div_q == '0);
  assign wr_en = pix_ce_in & (wr_addr_q != LMAX);
  always_comb begin
    hs_d = hsync_in;
    hs_prev_d = hs_q;
    vs_d = vsync_in;
    wr_sel_d = wr_sel_q ^ hs_edge;
    wr_addr_d = hs_edge ? '0 : wr_addr_q + (AW+1)'(wr_en);
    line_len_d = hs_edge ? wr_addr_q + (AW+1)'(wr_en) : line_len_q;
    overflow_d = overflow_q | (pix_ce_in & ~wr_en);
    per_cnt_d = hs_edge ? 16'd1 : per_cnt_q + 16'(per_cnt_q != 16'hFFFF);
    half_d = hs_edge ? per_cnt_q >> 1 : half_q;
    half_done_d = ~hs_edge & (half_done_q | hls);
    edges_d = edges_q + 2'(hs_edge & ~edges_q[1]);
    started_d = started_q | hls;
    div_d = (hls || div_q == 16'(OUT_DIV - 1)) ? '0 : div_q + 16'd1;
    vsync_out_d = hls ? vs_q : vsync_out_q;
    // a half-line start flushes the read pipeline so no stale pixel leaks past it
    p1_upd_d = ce | hls;
    p1_vld_d = ce & ~hls & line_valid & (state_q == ACTIVE);
    pix_d = p1_upd_q ? (p1_vld_q ? rd_data_q : '0) : pix_q;
    de_d = p1_upd_q ? p1_vld_q : de_q;
  end
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    rd_addr_d = rd_addr_q;
    if (hls) begin
      state_d = SYNC;
      step_d = '0;
      rd_addr_d = '0;
    end else if (ce) begin
      case (state_q)
        SYNC: begin
          step_d = step_q + 16'd1;
          if (step_q == 16'(HS_OUT_W - 1)) begin
            step_d = '0;
            state_d = BACK;
          end
        end
        BACK: begin
          step_d = step_q + 16'd1;
          if (step_q == 16'(BP_OUT - 1)) begin
            step_d = '0;
            state_d = (line_len_q == '0) ? IDLE : ACTIVE;
          end
        end
        ACTIVE: begin
          rd_addr_d = rd_addr_q + (AW+1)'(1);
          if (rd_addr_d == line_len_q) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hs_q <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q <= 1'b0;
      wr_sel_q <= 1'b0;
      wr_addr_q <= '0;
      line_len_q <= '0;
      rd_addr_q <= '0;
      overflow_q <= 1'b0;
      per_cnt_q <= '0;
      half_q <= '0;
      div_q <= '0;
      step_q <= '0;
      half_done_q <= 1'b0;
      started_q <= 1'b0;
      edges_q <= '0;
      vsync_out_q <= 1'b0;
      p1_upd_q <= 1'b0;
      p1_vld_q <= 1'b0;
      de_q <= 1'b0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      hs_q <= hs_d;
      hs_prev_q <= hs_prev_d;
      vs_q <= vs_d;
      wr_sel_q <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      line_len_q <= line_len_d;
      rd_addr_q <= rd_addr_d;
      overflow_q <= overflow_d;
      per_cnt_q <= per_cnt_d;
      half_q <= half_d;
      div_q <= div_d;
      step_q <= step_d;
      half_done_q <= half_done_d;
      started_q <= started_d;
      edges_q <= edges_d;
      vsync_out_q <= vsync_out_d;
      p1_upd_q <= p1_upd_d;
      p1_vld_q <= p1_vld_d;
      de_q <= de_d;
      pix_q <= pix_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_sel_q, wr_addr_q[AW-1:0]}] <= {blue_in, green_in, red_in};
    rd_data_q <= mem[{~wr_sel_q, rd_addr_q[AW-1:0]}];
  end
  assign ce_out = ce;
  assign {blue_out, green_out, red_out} = pix_q;
  assign hsync_out = state_q == SYNC;
  assign vsync_out = vsync_out_q;
  assign de_out = de_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_cga_scandoubler.sv
// tb_cga_scandoubler: directed bench for cga_scandoubler with HS_OUT_W=4, BP_OUT=2, OUT_DIV=1.
module tb_cga_scandoubler;
  logic clk = 1'b0;
  logic reset, pix_ce_in, hsync_in, vsync_in;
  logic [5:0] red_in, green_in, blue_in;
  logic ce_out, hsync_out, vsync_out, de_out, overflow;
  logic [5:0] red_out, green_out, blue_out;
  int cyc = 0;
  int passed = 0;
  int fails = 0;
  int total = 0;
  int snap_at = -1;
  logic [22:0] snap = '1;
  int ts[16];
  int ln = 0;
  bit use_tbl = 1'b1;
  bit hs_p = 1'b0;
  bit vs_p = 1'b0;
  int de_t[$];
  logic [17:0] de_px[$];
  int hs_rise[$];
  int hs_fall[$];
  int vs_rise[$];
  int vs_fall[$];
  logic [17:0] tbl [4] = '{18'h00001, 18'h00FC0, 18'h3F000, 18'h3FFFF};
  cga_scandoubler #(.LINE_MAX(1024), .OUT_DIV(1), .HS_OUT_W(4), .BP_OUT(2)) dut (
    .clk(clk), .reset(reset), .pix_ce_in(pix_ce_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ce_out(ce_out), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    #2;
    if (hsync_out && !hs_p) hs_rise.push_back(cyc);
    if (!hsync_out && hs_p) hs_fall.push_back(cyc);
    if (vsync_out && !vs_p) vs_rise.push_back(cyc);
    if (!vsync_out && vs_p) vs_fall.push_back(cyc);
    hs_p = hsync_out;
    vs_p = vsync_out;
    if (de_out) begin
      de_t.push_back(cyc);
      de_px.push_back({blue_out, green_out, red_out});
    end
    if (cyc == snap_at) snap = {ce_out, hsync_out, vsync_out, de_out, overflow, blue_out, green_out, red_out};
  end
  function automatic logic [17:0] pat(input int k);
    return use_tbl ? tbl[k[1:0]] : 18'(k * 7 + 3);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    de_t.delete();
    de_px.delete();
    hs_rise.delete();
    hs_fall.delete();
    vs_rise.delete();
    vs_fall.delete();
  endtask
  // one input line: hsync for 4 clk, then npix pixels every 2 clk starting at offset 10
  task automatic run_line(input int per, input int npix, input logic vs, input int rst_at = -1);
    ts[ln] = cyc;
    ln++;
    for (int c = 0; c < per; c++) begin
      int k;
      k = (c - 10) / 2;
      hsync_in = (c < 4);
      vsync_in = vs;
      reset = (c == rst_at);
      pix_ce_in = (c >= 10) && (c % 2 == 0) && (k < npix);
      {blue_in, green_in, red_in} = pix_ce_in ? pat(k) : 18'h0;
      if (c == rst_at) snap_at = cyc + 1;
      @(negedge clk);
    end
  endtask
  initial begin
    reset = 1'b1;
    pix_ce_in = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    {blue_in, green_in, red_in} = '0;
    repeat (3) @(negedge clk);
    check("rst_ce", 32'(ce_out), 0);
    check("rst_rgb", 32'({blue_out, green_out, red_out}), 0);
    check("rst_hs", 32'(hsync_out), 0);
    check("rst_vs", 32'(vsync_out), 0);
    check("rst_de", 32'(de_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    clr();
    run_line(40, 4, 1'b0);
    check("l1_no_de", de_t.size(), 0);
    check("l1_hs_cnt", hs_rise.size(), 1);
    check("l1_hs_rise", hs_rise[0], ts[0] + 2);
    run_line(40, 4, 1'b0);
    clr();
    run_line(40, 4, 1'b0);
    check("dbl_de_cnt", de_t.size(), 8);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) begin
        check($sformatf("dbl_t%0d_%0d", p, i), de_t[p*4+i], ts[2] + 10 + 20 * p + i);
        check($sformatf("dbl_px%0d_%0d", p, i), 32'(de_px[p*4+i]), 32'(tbl[i]));
      end
    check("dbl_hs_rise0", hs_rise[0], ts[2] + 2);
    check("dbl_hs_rise1", hs_rise[1], ts[2] + 22);
    check("dbl_hs_fall0", hs_fall[0], ts[2] + 6);
    use_tbl = 1'b0;
    run_line(2200, 1030, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    clr();
    run_line(2200, 4, 1'b0);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_de_cnt", de_t.size(), 2048);
    check("ovf_t0", de_t[0], ts[4] + 10);
    check("ovf_px0", 32'(de_px[0]), 3);
    check("ovf_t1023", de_t[1023], ts[4] + 1033);
    check("ovf_px1023", 32'(de_px[1023]), 32'(18'(1023 * 7 + 3)));
    check("ovf_t1024", de_t[1024], ts[4] + 1110);
    check("ovf_t2047", de_t[2047], ts[4] + 2133);
    clr();
    run_line(1000, 0, 1'b0);
    run_line(1000, 0, 1'b0);
    check("split_cnt", hs_rise.size(), 3);
    check("split_r1", hs_rise[1], ts[6] + 2);
    check("split_r2", hs_rise[2], ts[6] + 502);
    run_line(700, 300, 1'b0);
    clr();
    run_line(400, 0, 1'b0);
    run_line(100, 0, 1'b0);
    check("trunc_de_cnt", de_t.size(), 343);
    check("trunc_t0", de_t[0], ts[8] + 10);
    check("trunc_t299", de_t[299], ts[8] + 309);
    check("trunc_px299", 32'(de_px[299]), 32'(18'(299 * 7 + 3)));
    check("trunc_t300", de_t[300], ts[8] + 360);
    check("trunc_t342", de_t[342], ts[9] + 2);
    check("trunc_px342", 32'(de_px[342]), 32'(18'(42 * 7 + 3)));
    check("trunc_hs_restart", hs_rise[2], ts[9] + 2);
    clr();
    run_line(100, 0, 1'b1);
    run_line(100, 0, 1'b1);
    run_line(100, 4, 1'b0);
    check("vs_rise_cnt", vs_rise.size(), 1);
    check("vs_rise", vs_rise[0], ts[10] + 2);
    check("vs_fall", vs_fall[0], ts[12] + 2);
    clr();
    run_line(100, 4, 1'b0, 11);
    run_line(100, 0, 1'b0);
    check("mrst_outs", 32'(snap), 0);
    check("mrst_de_cnt", de_t.size(), 2);
    check("mrst_t1", de_t[1], ts[13] + 11);
    check("mrst_px1", 32'(de_px[1]), 10);
    check("mrst_hs_cnt", hs_rise.size(), 2);
    check("mrst_hs_rise", hs_rise[1], ts[14] + 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
